seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl_if.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//   Bundles the application-side write/control signals and the board-side
//   display drive of the seven-segment scan controller.
//
//   load         1         single-cycle write strobe for load_data
//   load_data    4*DIGITS  display word, nibble i is digit i (digit 0 rightmost)
//   blank_mask   DIGITS    bit i = 1 forces digit i dark (live)
//   lz_suppress  1         1 = suppress leading zeros (live)
//   seg_data     7         active-low segments {g,f,e,d,c,b,a}
//   dig_sel      DIGITS    active-low digit enables, at most one low
//   frame_start  1         one-cycle pulse when the scan index wraps to 0
//
//   master : application/testbench side (drives load/data/controls)
//   slave  : the scan controller
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_suppress;
  logic [6:0]            seg_data;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_start;

  modport master (
    output load, load_data, blank_mask, lz_suppress,
    input  seg_data, dig_sel, frame_start
  );

  modport slave (
    input  load, load_data, blank_mask, lz_suppress,
    output seg_data, dig_sel, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode DIGITS-digit
//   seven-segment display. One digit is driven at a time for SHOW_CYCLES
//   clocks, separated by GUARD_CYCLES clocks with every digit off so the
//   previous digit's segments never ghost onto the next one.
//
//   Updates are double-buffered: a load lands in a shadow word and is only
//   copied to the displayed word when the scan wraps from the last digit
//   back to digit 0, so a frame never mixes old and new values.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous, active-high reset
//     bus   seg_scan_ctrl_if.slave (load/load_data/blank_mask/lz_suppress in,
//           seg_data/dig_sel/frame_start out)
// ---------------------------------------------------------------------------

// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg_hex7_dec (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'b111_1111;
    case (hex)
      4'h0: seg_n = 7'b100_0000;
      4'h1: seg_n = 7'b111_1001;
      4'h2: seg_n = 7'b010_0100;
      4'h3: seg_n = 7'b011_0000;
      4'h4: seg_n = 7'b001_1001;
      4'h5: seg_n = 7'b001_0010;
      4'h6: seg_n = 7'b000_0010;
      4'h7: seg_n = 7'b111_1000;
      4'h8: seg_n = 7'b000_0000;
      4'h9: seg_n = 7'b001_0000;
      4'hA: seg_n = 7'b000_1000;
      4'hB: seg_n = 7'b000_0011;
      4'hC: seg_n = 7'b100_0110;
      4'hD: seg_n = 7'b010_0001;
      4'hE: seg_n = 7'b000_0110;
      4'hF: seg_n = 7'b000_1110;
      default: seg_n = 7'b111_1111;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int MAXC  = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W = 4 * DIGITS;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              frame_start_q, frame_start_d;

  logic              show_done;
  logic              guard_done;
  logic              wrap;

  // -------------------------------------------------------------------------
  // Scan sequencing and double buffer
  // -------------------------------------------------------------------------
  assign show_done  = (state_q == ST_SHOW)  && (cnt_q == SHOW_LAST);
  assign guard_done = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST);
  assign wrap       = show_done && (idx_q == IDX_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_start_d = wrap;

    if (state_q == ST_GUARD) begin
      if (guard_done) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (show_done) begin
        state_d = ST_GUARD;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A load landing exactly on the wrap goes straight to the display and
    // supersedes whatever was waiting in the shadow word.
    if (wrap) begin
      if (bus.load) begin
        active_d = bus.load_data;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      shadow_d  = bus.load_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_GUARD;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  // lz_zero[i] is set when nibbles DIGITS-1 down to i are all zero, i.e.
  // digit i is a leading zero.
  logic [DIGITS-1:0] lz_zero;
  logic              zero_run;

  always_comb begin
    lz_zero  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (active_q[4*i +: 4] == 4'h0);
      lz_zero[i] = zero_run;
    end
  end

  logic [3:0] cur_nib;
  logic [6:0] dec_seg;
  logic       cur_blank;

  assign cur_nib = active_q[4*idx_q +: 4];

  seg_hex7_dec u_dec (
    .hex   (cur_nib),
    .seg_n (dec_seg)
  );

  // Digit 0 is exempt from suppression so an all-zero word still reads "0".
  assign cur_blank = bus.blank_mask[idx_q]
                   | (bus.lz_suppress && (idx_q != '0) && lz_zero[idx_q]);

  logic [DIGITS-1:0] dig_sel_c;
  logic [6:0]        seg_data_c;

  always_comb begin
    dig_sel_c  = '1;
    seg_data_c = 7'b111_1111;
    if (state_q == ST_SHOW) begin
      dig_sel_c[idx_q] = 1'b0;
      seg_data_c       = cur_blank ? 7'b111_1111 : dec_seg;
    end
  end

  assign bus.dig_sel     = dig_sel_c;
  assign bus.seg_data    = seg_data_c;
  assign bus.frame_start = frame_start_q;

endmodule
